// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------------------------------------------------------------------
// Runs one read or write transaction on a synchronous data memory, starting
// from the registered address of the memory address register. It drives
// address, write data, enable and write-enable toward memory. It inserts a
// programmable number of wait states, then waits on the memory ready
// handshake. Read data is captured into a holding register, and completion is
// signalled with a one-cycle done pulse.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   - a WAIT-cycle timeout aborts the transaction after TIMEOUT
//               cycles, pulsing err together with done
//   undefined - WAIT lasts until mem_ready; err is tied low
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   addr_in    in   [AW] address from the address register
//   wdata_in   in   [DW] write data from the data register
//   rd_req     in   read request, sampled in IDLE only
//   wr_req     in   write request, sampled in IDLE only (wins over rd_req)
//   busy       out  transaction in progress
//   done       out  one-cycle completion pulse
//   rdata      out  [DW] captured read data
//   mem_addr   out  [AW] memory address
//   mem_wdata  out  [DW] memory write data
//   mem_en     out  memory enable
//   mem_we     out  memory write enable
//   mem_rdata  in   [DW] memory read data
//   mem_ready  in   memory ready/ack
//   err        out  timeout pulse
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int AW          = 15,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 63
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    input  logic          rd_req,
    input  logic          wr_req,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_en,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        DONE
    } state_t;

    // Elaboration-time parameter sanity checks
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_badWait
        $error("mem_access_ctrl: WAIT_CYCLES must be 0..15");
    end
    if (TIMEOUT < 1) begin : g_badTimeout
        $error("mem_access_ctrl: TIMEOUT must be at least 1");
    end

    state_t        r_state;
    state_t        w_nextState;
    logic [3:0]    r_waitCnt;
    logic          r_opWrite;
    logic          r_busy;
    logic          r_done;
    logic          r_memEn;
    logic          r_memWe;
    logic [AW-1:0] r_memAddr;
    logic [DW-1:0] r_memWdata;
    logic [DW-1:0] r_rdata;
    logic          w_accept;
    logic          w_readyOk;
    logic          w_timeout;
    logic          w_opNext;

    assign w_accept  = (r_state == IDLE) && (rd_req || wr_req);
    // Ready only counts once the wait states have been used up
    assign w_readyOk = (r_state == WAIT) && (r_waitCnt == 4'd0) && mem_ready;
    // The operation for the next cycle: freshly sampled on accept, else held
    assign w_opNext  = (r_state == IDLE) ? wr_req : r_opWrite;

`ifdef MEM_TIMEOUT_EN
    localparam int ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [ToW-1:0] r_toCnt;
    logic           r_err;

    // Completion by ready takes priority over a timeout on the same edge
    assign w_timeout = (r_state == WAIT) && !w_readyOk &&
                       (r_toCnt == ToW'(TIMEOUT - 1));

    // Count WAIT cycles; cleared in SETUP so each transaction starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toCnt <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == SETUP) begin
                r_toCnt <= '0;
            end else if (r_state == WAIT) begin
                r_toCnt <= r_toCnt + 1'b1;
            end
            r_err <= w_timeout;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = SETUP;
            SETUP:   w_nextState = WAIT;
            WAIT:    if (w_readyOk || w_timeout) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State, datapath and registered outputs. Outputs are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_waitCnt  <= 4'd0;
            r_opWrite  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_nextState;

            if (w_accept) begin
                r_memAddr  <= addr_in;
                r_memWdata <= wdata_in;
                r_opWrite  <= wr_req;
            end

            if (r_state == SETUP) begin
                r_waitCnt <= 4'(WAIT_CYCLES);
            end else if (r_state == WAIT && r_waitCnt != 4'd0) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end

            if (w_readyOk && !r_opWrite) begin
                r_rdata <= mem_rdata;
            end

            r_busy  <= (w_nextState != IDLE);
            r_done  <= (w_nextState == DONE);
            r_memEn <= (w_nextState == SETUP) || (w_nextState == WAIT);
            r_memWe <= ((w_nextState == SETUP) || (w_nextState == WAIT)) && w_opNext;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_en    = r_memEn;
    assign mem_we    = r_memWe;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Downstream neighbour of the memory address register. Consumes its registered 15-bit address and runs one read or write transaction on the synchronous data memory.
- Owns the address, write-data and strobe timing toward memory, with programmable wait states and a memory ready handshake.
- On a read, captures memory data into a holding register that feeds the data register/bus, and signals completion with a one-cycle pulse to the control unit.

Parameters:
AW, 15, address width; matches the address register output.
DW, 16, data width.
WAIT_CYCLES, 2, minimum wait-state count in WAIT before ready is honoured (0..15).
TIMEOUT, 63, maximum WAIT cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
addr_in  in  AW  address from the address register
wdata_in  in  DW  write data from the data register
rd_req  in  1  read request, sampled in IDLE only
wr_req  in  1  write request, sampled in IDLE only
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
rdata  out  DW  captured read data
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_rdata  in  DW  memory read data
mem_ready  in  1  memory ready/ack
err  out  1  timeout pulse (constant 0 without MEM_TIMEOUT_EN)

Behaviour:
- Decided: single clock clk; reset rst_n is asynchronous, active-low.
- Reset (asserted at any time, including mid-transaction):
  - State returns to IDLE; wait counter cleared.
  - busy, done, mem_en, mem_we, err = 0; mem_addr, mem_wdata, rdata = 0.
  - An in-flight transaction is dropped with no done pulse.
- FSM states: IDLE, SETUP, WAIT, DONE.
- IDLE:
  - On an edge with rd_req or wr_req high: latch addr_in to mem_addr and wdata_in to mem_wdata, latch op, go to SETUP.
  - Both requests high: write wins (last-assignment priority, same as the address register's second load enable).
- SETUP (1 cycle):
  - busy=1, mem_en=1, mem_we=op_write.
  - Load counter with WAIT_CYCLES; go to WAIT.
- WAIT:
  - mem_en=1, mem_we=op_write, busy=1.
  - Counter decrements each cycle while nonzero.
  - Exit to DONE on the edge where counter==0 and mem_ready==1. If read, capture mem_rdata into rdata on that same edge.
  - mem_ready before the counter reaches 0 is ignored.
- DONE (1 cycle):
  - done=1, busy=1, mem_en=0, mem_we=0; next state is IDLE.
- Outputs are registered.
  - mem_addr and mem_wdata are stable from SETUP through DONE and hold their last value in IDLE.
  - rdata holds until the next completed read; writes and aborts do not alter it.
- Latency (mem_ready tied high): request edge -> done high after 3+WAIT_CYCLES cycles, i.e. 5 for the default. Back-to-back: a new request is accepted on the first IDLE edge after DONE.
- Requests while busy are ignored, not queued; the requester must hold rd_req/wr_req until it sees done.
- Address is passed through unchanged, full 15-bit range including 0x7FFF; no increment, so no wrap.
- WAIT_CYCLES=0: WAIT exits on the first cycle with mem_ready high.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a second counter runs in WAIT. If mem_ready has not completed the transaction after TIMEOUT WAIT cycles, the FSM goes to DONE with err=1 together with done=1 for that one cycle. rdata is not updated.
- Undefined: no timeout counter, WAIT lasts indefinitely until mem_ready, and err is tied 0.

Test Plan:
- Reset mid-WAIT: read 0x0010, assert rst_n=0 during WAIT -> all outputs 0 immediately (asynchronous), no done pulse; after release, the FSM accepts a new request.
- Read, ready tied 1, WAIT_CYCLES=2: rd_req, addr_in=0x1234, mem_rdata=0xBEEF -> mem_en high 4 cycles, mem_we=0, done 5 cycles after the request edge, rdata=0xBEEF.
- Write with late ready: wr_req, addr_in=0x7FFF, wdata_in=0xA5A5, mem_ready rises 6 cycles after SETUP -> mem_addr=0x7FFF, mem_wdata=0xA5A5, mem_we=1 through WAIT, done the cycle after ready, rdata unchanged.
- Simultaneous requests: rd_req=wr_req=1, addr_in=0x0001 -> write performed (mem_we=1), rdata unchanged.
- Request while busy: during a read, pulse wr_req with addr_in=0x0ABC -> ignored, mem_addr holds the original address, single done pulse.
- MEM_TIMEOUT_EN, TIMEOUT=8, mem_ready=0 -> done=1 and err=1 in the same cycle after 8 WAIT cycles, rdata not updated, busy drops the next cycle.
